// File: rtl/instr_encoder_pkg.sv
// Shared RV32I immediate-format definitions: format encodings, field positions
// and the merge helper that inserts an immediate into a base instruction word.
package instr_encoder_pkg;

  localparam logic [1:0] FMT_L  = 2'b00;
  localparam logic [1:0] FMT_I  = 2'b01;
  localparam logic [1:0] FMT_SB = 2'b10;
  localparam logic [1:0] FMT_JU = 2'b11;

  localparam int unsigned IMM12_MSB  = 31;
  localparam int unsigned IMM12_LSB  = 20;
  localparam int unsigned SB_HI_MSB  = 31;
  localparam int unsigned SB_HI_LSB  = 25;
  localparam int unsigned SB_LO_MSB  = 11;
  localparam int unsigned SB_LO_LSB  = 7;
  localparam int unsigned IMM20_MSB  = 31;
  localparam int unsigned IMM20_LSB  = 12;

  // Only imm[19:0] can reach the packed word, so S1 keeps just those bits.
  typedef struct packed {
    logic [31:0] base;
    logic [19:0] imm;
    logic [1:0]  sel;
    logic        err;
  } s1_req_t;

  function automatic logic [31:0] merge_imm(input logic [31:0] base,
                                            input logic [19:0] imm,
                                            input logic [1:0]  sel);
    logic [31:0] ir;
    ir = base;
    case (sel)
      FMT_L, FMT_I: ir[IMM12_MSB:IMM12_LSB] = imm[11:0];
      FMT_SB: begin
        ir[SB_HI_MSB:SB_HI_LSB] = imm[11:5];
        ir[SB_LO_MSB:SB_LO_LSB] = imm[4:0];
      end
      FMT_JU:       ir[IMM20_MSB:IMM20_LSB] = imm[19:0];
      default:      ir = base;
    endcase
    return ir;
  endfunction

endpackage

// File: rtl/instr_encoder_range_check.sv
// Combinational check that an immediate is representable in the selected format.
module imm_range_check
  import instr_encoder_pkg::*;
(
  input  logic [31:0] in_imm,
  input  logic [1:0]  in_sel,
  output logic        err
);

  logic [31:0] sext_hi_s;

  // I-format is signed: bits 31..11 must all be copies of the sign bit.
  always_comb begin
    sext_hi_s = 32'($signed(in_imm) >>> 11);
    err       = 1'b0;
    case (in_sel)
      FMT_L, FMT_SB: err = ((in_imm >> 12) != 32'd0);
      FMT_I:         err = (sext_hi_s != 32'd0) && (sext_hi_s != 32'hFFFF_FFFF);
      FMT_JU:        err = ((in_imm >> 20) != 32'd0);
      default:       err = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage immediate packer: S1 captures the request and its range verdict,
// S2 holds the merged instruction word; valid/ready handshakes on both sides.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_base,
  input  logic [31:0]         in_imm,
  input  logic [1:0]          in_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_ir,
  output logic                out_err,
  input  logic                clr_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [ERRCNT_W-1:0] CNT_MAX  = {ERRCNT_W{1'b1}};
  localparam logic [ERRCNT_W-1:0] CNT_ZERO = {ERRCNT_W{1'b0}};
  localparam logic [ERRCNT_W-1:0] CNT_ONE  = {{(ERRCNT_W-1){1'b0}}, 1'b1};

  s1_req_t             s1_q, s1_d;
  logic                s1_valid_q, s1_valid_d;
  logic                s2_valid_q, s2_valid_d;
  logic [31:0]         ir_q, ir_d;
  logic                err_q, err_d;
  logic [ERRCNT_W-1:0] cnt_q, cnt_d;

  logic range_err_s;
  logic s2_free_s;
  logic in_fire_s;
  logic s2_load_s;
  logic out_fire_s;

  imm_range_check u_range_check (
    .in_imm (in_imm),
    .in_sel (in_sel),
    .err    (range_err_s)
  );

  assign s2_free_s  = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_free_s;
  assign in_fire_s  = in_valid && in_ready;
  assign s2_load_s  = s1_valid_q && s2_free_s;
  assign out_fire_s = s2_valid_q && out_ready;

  // S1 and S2 next-state: each stage holds unless its downstream frees it.
  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    ir_d       = ir_q;
    err_d      = err_q;
    if (in_fire_s) begin
      s1_d       = '{base: in_base, imm: in_imm[19:0], sel: in_sel, err: range_err_s};
      s1_valid_d = 1'b1;
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_load_s) begin
      s2_valid_d = 1'b1;
      ir_d       = merge_imm(s1_q.base, s1_q.imm, s1_q.sel);
      err_d      = s1_q.err;
    end else if (out_fire_s) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Error counter: clear wins over a coincident increment; saturates at max.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_err) begin
      cnt_d = CNT_ZERO;
    end else if (out_fire_s && err_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset discarding any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= {$bits(s1_req_t){1'b0}};
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      ir_q       <= 32'd0;
      err_q      <= 1'b0;
      cnt_q      <= CNT_ZERO;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      ir_q       <= ir_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_ir    = ir_q;
  assign out_err   = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed vectors.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic [1:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic        out_err;
  logic        clr_err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ERRCNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_base   (in_base),
    .in_imm    (in_imm),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ir    (out_ir),
    .out_err   (out_err),
    .clr_err   (clr_err),
    .err_count (err_count)
  );

  logic [31:0] fmt_base [8] = '{32'h0000_2023, 32'h0000_006F, 32'h0000_3003, 32'h0000_0013,
                                32'h0000_0013, 32'h0000_0037, 32'h0000_2023, 32'hFFFF_FFFF};
  logic [31:0] fmt_imm  [8] = '{32'h0000_007F, 32'h0001_2345, 32'h0000_0ABC, 32'hFFFF_F800,
                                32'h0000_07FF, 32'h0010_0000, 32'h0000_1000, 32'h0000_0000};
  logic [1:0]  fmt_sel  [8] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10};
  logic [31:0] fmt_ir   [8] = '{32'h0600_2FA3, 32'h1234_506F, 32'hABC0_3003, 32'h8000_0013,
                                32'h7FF0_0013, 32'h0000_0037, 32'h0000_2023, 32'h01FF_F07F};
  logic        fmt_err  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  logic [31:0] b2b_ir   [4] = '{32'h0010_0013, 32'h0020_0013, 32'h0030_0013, 32'h0040_0013};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_base = 32'd0; in_imm = 32'd0; in_sel = 2'b00;
    out_ready = 1'b0; clr_err = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_ir !== 32'd0) begin errors++; $display("FAIL reset_out_ir: got %h want 00000000", out_ir); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    in_base = 32'h0000_0013; in_imm = 32'hFFFF_FFFF; in_sel = 2'b01; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid_n2: got %b want 1", out_valid); end
    checks++; if (out_ir !== 32'hFFF0_0013) begin errors++; $display("FAIL lat_out_ir: got %h want fff00013", out_ir); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL lat_out_err: got %b want 0", out_err); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_single_emit: got %b want 0", out_valid); end
  endtask

  task automatic test_error();
    in_base = 32'h0000_0013; in_imm = 32'h0000_0800; in_sel = 2'b01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (out_ir !== 32'h8000_0013) begin errors++; $display("FAIL err_out_ir: got %h want 80000013", out_ir); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL err_out_err: got %b want 1", out_err); end
    step();
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL err_count_one: got %0d want 1", err_count); end
  endtask

  task automatic test_formats();
    int sent = 0;
    int got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (sent < 8) begin
        in_valid = 1'b1; in_base = fmt_base[sent]; in_imm = fmt_imm[sent]; in_sel = fmt_sel[sent];
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        if (got < 8) begin
          checks++; if (out_ir !== fmt_ir[got]) begin errors++; $display("FAIL fmt_ir[%0d]: got %h want %h", got, out_ir, fmt_ir[got]); end
          checks++; if (out_err !== fmt_err[got]) begin errors++; $display("FAIL fmt_err[%0d]: got %b want %b", got, out_err, fmt_err[got]); end
        end else begin
          checks++; errors++; $display("FAIL fmt_extra_output: got %h want none", out_ir);
        end
        got++;
      end
      step();
      if (in_valid) sent++;
    end
    in_valid = 1'b0;
    checks++; if (got != 8) begin errors++; $display("FAIL fmt_count: got %0d want 8", got); end
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL fmt_err_count: got %0d want 3", err_count); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    logic acc;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 3);
      if (sent < 4) begin
        in_valid = 1'b1; in_base = 32'h0000_0013; in_imm = 32'(sent + 1); in_sel = 2'b01;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_stall: got %b want 0", in_ready); end
        checks++; if (sent != 2) begin errors++; $display("FAIL b2b_accepts_before_stall: got %0d want 2", sent); end
        checks++; if (out_ir !== b2b_ir[0]) begin errors++; $display("FAIL b2b_stall_hold: got %h want %h", out_ir, b2b_ir[0]); end
      end
      acc = in_valid && in_ready;
      if (out_valid === 1'b1 && out_ready) begin
        if (got < 4) begin
          checks++; if (out_ir !== b2b_ir[got]) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", got, out_ir, b2b_ir[got]); end
        end else begin
          checks++; errors++; $display("FAIL b2b_duplicate: got %h want none", out_ir);
        end
        got++;
      end
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", got); end
  endtask

  task automatic test_saturation();
    int sent = 0;
    int w = 0;
    out_ready = 1'b1;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL sat_clear: got %0d want 0", err_count); end
    for (int cyc = 0; cyc < 265; cyc++) begin
      in_valid = (sent < 260);
      in_base = 32'h0000_0003; in_imm = 32'hFFFF_0000; in_sel = 2'b00;
      step();
      if (in_valid) sent++;
    end
    in_valid = 1'b0;
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_err_count: got %0d want 255", err_count); end
    in_valid = 1'b1; in_imm = 32'h0000_1000; in_sel = 2'b10;
    step();
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && w < 10) begin
      step();
      w++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_wait_output: got %b want 1", out_valid); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL sat_clr_priority: got %0d want 0", err_count); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_base = 32'h0000_0037; in_imm = 32'h0020_0000; in_sel = 2'b11;
    step();
    in_valid = 1'b0;
    step();
    step();
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL mid_pre_count: got %0d want 1", err_count); end
    out_ready = 1'b0;
    in_valid = 1'b1; in_base = 32'h0000_006F; in_imm = 32'h000A_BCDE; in_sel = 2'b11;
    step();
    in_imm = 32'h0010_0000;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_full_valid: got %b want 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full_ready: got %b want 0", in_ready); end
    rst = 1'b1; out_ready = 1'b1; in_imm = 32'h0000_0123;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", err_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
    checks++; if (out_ir !== 32'd0) begin errors++; $display("FAIL mid_rst_ir: got %h want 00000000", out_ir); end
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_discarded_emitted: got %0d outputs want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_error();
    test_formats();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ERRCNT_W, default 8: width of the error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream presents a request.
REQ-005 in_ready  output  1  block accepts the request this cycle.
REQ-006 in_base  input  32  instruction word carrying opcode/rd/rs/funct fields; immediate bit positions are ignored.
REQ-007 in_imm  input  32  immediate value to pack.
REQ-008 in_sel  input  2  format: 00 L (load, zero-ext 12b), 01 I (sign-ext 12b), 10 S/B (zero-ext 12b split), 11 J/U (zero-ext 20b).
REQ-009 out_valid  output  1  packed instruction available.
REQ-010 out_ready  input  1  downstream accepts the output this cycle.
REQ-011 out_ir  output  32  packed instruction word.
REQ-012 out_err  output  1  in_imm was not representable in the selected format.
REQ-013 clr_err  input  1  synchronous clear of err_count.
REQ-014 err_count  output  ERRCNT_W  saturating count of erroneous requests emitted.

Function
REQ-015 Transfer occurs on in_valid&in_ready (input) and out_valid&out_ready (output); no other event moves data.
REQ-016 Two register stages: S1 captures request and computes the range check; S2 holds merged out_ir/out_err.
REQ-017 Latency: an input accepted in cycle N SHALL appear with out_valid=1 in cycle N+2 when not stalled; throughput is one per cycle.
REQ-018 in_ready = !S1_valid | (!S2_valid | out_ready); combinational, no dependency on in_valid.
REQ-019 Under stall, S1 and S2 hold their contents; no request is dropped, duplicated or reordered.
REQ-020 Range check: L and S/B err when in_imm[31:12]!=0; I errs when in_imm[31:11] is not all-equal; J/U errs when in_imm[31:20]!=0.
REQ-021 Merge L/I: out_ir[31:20]=imm[11:0], out_ir[19:0]=base[19:0].
REQ-022 Merge S/B: out_ir[31:25]=imm[11:5], out_ir[11:7]=imm[4:0], all other bits from base.
REQ-023 Merge J/U: out_ir[31:12]=imm[19:0], out_ir[11:0]=base[11:0].
REQ-024 On error the packed word is still emitted using truncated imm bits, with out_err=1.
REQ-025 Round-trip: for any non-error output, decoding out_ir with the team's immediate generator under the same in_sel SHALL return in_imm exactly.
REQ-026 err_count increments by 1 when an output with out_err=1 transfers; saturates at 2^ERRCNT_W-1.
REQ-027 clr_err has priority over a simultaneous increment: count becomes 0.
REQ-028 out_ir/out_err SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-029 On rst: S1_valid=0, S2_valid=0, out_valid=0, out_ir=0, out_err=0, err_count=0; in_ready=1 in the cycle after reset.
REQ-030 rst mid-operation discards all in-flight requests without emitting them; rst has priority over every other input.

Structure
REQ-031 The format encodings (L/I/SB/JU) and field bit-position constants SHALL live in the shared RV32I package, shared with the immediate generator.
REQ-032 One sub-module, imm_range_check (combinational: in_imm, in_sel -> err), SHALL be instantiated in S1.

Verification
REQ-033 base=0x00000013, imm=0xFFFFFFFF, sel=01 -> out_ir=0xFFF00013, out_err=0, valid 2 cycles after accept.
REQ-034 base=0x00000013, imm=0x00000800, sel=01 -> out_ir=0x80000013, out_err=1, err_count=1.
REQ-035 base=0x00002023, imm=0x0000007F, sel=10 -> out_ir=0x06002FA3, out_err=0; base=0x6F, imm=0x00012345, sel=11 -> out_ir=0x1234506F.
REQ-036 Stream of 4 back-to-back requests with out_ready=0 for 3 cycles -> in_ready falls after 2 accepts, all 4 emerge in order, no duplicates.
REQ-037 260 erroneous requests -> err_count=255 (ERRCNT_W=8); clr_err asserted in the same cycle as an error transfer -> err_count=0.
REQ-038 rst asserted with both stages full -> next cycle out_valid=0, err_count=0, in_ready=1; the discarded words never appear.
